// File: rtl/demux_1to2_pipe_pkg.sv
// Shared constants for the 1-to-2 demultiplexer: lane encodings and default payload width.
package demux_1to2_pipe_pkg;

  localparam logic LANE0        = 1'b0;
  localparam logic LANE1        = 1'b1;
  localparam int   DEFAULT_SIZE = 32;

endpackage

// File: rtl/demux_lane_fifo.sv
// Per-lane FIFO with registered empty/full flags; head reads as zero while empty.
module demux_lane_fifo
  import demux_1to2_pipe_pkg::*;
#(
  parameter int size  = DEFAULT_SIZE,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [size-1:0] wdata,
  output logic [size-1:0] rdata,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [size-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic [OCC_W-1:0] count_next;
  logic             empty_q;
  logic             full_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + OCC_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - OCC_W'(1);
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_next;
      empty_q <= (count_next == '0);
      full_q  <= (count_next == OCC_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty_q ? '0 : mem[rd_ptr];
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/demux_1to2_pipe.sv
// Registered 1-to-2 demultiplexer: steers one valid/ready stream into two independently buffered lanes.
module demux_1to2_pipe
  import demux_1to2_pipe_pkg::*;
#(
  parameter int size  = DEFAULT_SIZE,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [size-1:0]  data_i,
  input  logic             select_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [size-1:0]  data0_o,
  output logic             valid0_o,
  input  logic             ready0_i,
  output logic [size-1:0]  data1_o,
  output logic             valid1_o,
  input  logic             ready1_i,
  output logic [CNT_W-1:0] cnt0_o,
  output logic [CNT_W-1:0] cnt1_o
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic pop0, pop1;
  logic accept;

  // Only the selected lane's registered full flag gates acceptance; no path from consumer readies.
  assign ready_o = ~rst_i & ~((select_i == LANE1) ? full1 : full0);
  assign accept  = valid_i & ready_o;
  assign push0   = accept & (select_i == LANE0);
  assign push1   = accept & (select_i == LANE1);

  assign valid0_o = ~empty0;
  assign valid1_o = ~empty1;
  assign pop0     = valid0_o & ready0_i;
  assign pop1     = valid1_o & ready1_i;

  demux_lane_fifo #(.size(size), .DEPTH(DEPTH)) u_lane0 (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push0),
    .pop   (pop0),
    .wdata (data_i),
    .rdata (data0_o),
    .empty (empty0),
    .full  (full0)
  );

  demux_lane_fifo #(.size(size), .DEPTH(DEPTH)) u_lane1 (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push1),
    .pop   (pop1),
    .wdata (data_i),
    .rdata (data1_o),
    .empty (empty1),
    .full  (full1)
  );

  // Debug delivery counters wrap silently.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt0_o <= '0;
      cnt1_o <= '0;
    end else begin
      if (pop0) cnt0_o <= cnt0_o + CNT_W'(1);
      if (pop1) cnt1_o <= cnt1_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux_1to2_pipe.sv
// Directed bench for demux_1to2_pipe: vector table for handshake cases plus streaming, wrap and reset sequences.
module tb_demux_1to2_pipe;

  typedef struct {
    logic        sel;
    logic        valid;
    logic [31:0] data;
    logic        rdy0;
    logic        rdy1;
    logic        exp_ready;
    logic        exp_v0;
    logic [31:0] exp_d0;
    logic        exp_v1;
    logic [31:0] exp_d1;
    logic [7:0]  exp_c0;
    logic [7:0]  exp_c1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        sel = 1'b0;
  logic        valid = 1'b0;
  logic        rdy0 = 1'b0;
  logic        rdy1 = 1'b0;

  logic        ready, v0, v1;
  logic [31:0] d0, d1;
  logic [7:0]  c0, c1;

  logic        ready_w, v0_w, v1_w;
  logic [31:0] d0_w, d1_w;
  logic [3:0]  c0_w, c1_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_1to2_pipe dut (
    .clk_i(clk), .rst_i(rst), .data_i(data_in), .select_i(sel), .valid_i(valid),
    .ready_o(ready), .data0_o(d0), .valid0_o(v0), .ready0_i(rdy0),
    .data1_o(d1), .valid1_o(v1), .ready1_i(rdy1), .cnt0_o(c0), .cnt1_o(c1)
  );

  // Narrow-counter copy driven by the same stimulus to exercise counter wrap.
  demux_1to2_pipe #(.CNT_W(4)) dut_w (
    .clk_i(clk), .rst_i(rst), .data_i(data_in), .select_i(sel), .valid_i(valid),
    .ready_o(ready_w), .data0_o(d0_w), .valid0_o(v0_w), .ready0_i(rdy0),
    .data1_o(d1_w), .valid1_o(v1_w), .ready1_i(rdy1), .cnt0_o(c0_w), .cnt1_o(c1_w)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [31:0] d,
                               input logic r0, input logic r1);
    sel     = s;
    valid   = v;
    data_in = d;
    rdy0    = r0;
    rdy1    = r1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRow(input string tag, input vec_t t);
    checkOutput({tag, " ready"}, 64'(ready), 64'(t.exp_ready));
    checkOutput({tag, " valid0"}, 64'(v0), 64'(t.exp_v0));
    checkOutput({tag, " data0"}, 64'(d0), 64'(t.exp_d0));
    checkOutput({tag, " valid1"}, 64'(v1), 64'(t.exp_v1));
    checkOutput({tag, " data1"}, 64'(d1), 64'(t.exp_d1));
    checkOutput({tag, " cnt0"}, 64'(c0), 64'(t.exp_c0));
    checkOutput({tag, " cnt1"}, 64'(c1), 64'(t.exp_c1));
    checkOutput({tag, " narrow copy"},
                {ready_w, v0_w, v1_w, c0_w, c1_w, d0_w[15:0], d1_w[15:0]},
                {t.exp_ready, t.exp_v0, t.exp_v1, t.exp_c0[3:0], t.exp_c1[3:0],
                 t.exp_d0[15:0], t.exp_d1[15:0]});
  endtask

  vec_t vecs[$];

  initial begin
    // sel valid data rdy0 rdy1 | ready v0 d0 v1 d1 c0 c1
    vecs.push_back('{1, 1, 32'hDEAD_BEEF, 0, 1, 1, 0, 32'h0,  0, 32'h0,         0, 0}); // push lane 1
    vecs.push_back('{1, 0, 32'h0,         0, 1, 1, 0, 32'h0,  1, 32'hDEAD_BEEF, 0, 0}); // visible, popped
    vecs.push_back('{0, 0, 32'h0,         0, 1, 1, 0, 32'h0,  0, 32'h0,         0, 1}); // cnt1 = 1
    vecs.push_back('{0, 1, 32'hA1,        0, 1, 1, 0, 32'h0,  0, 32'h0,         0, 1}); // push A1
    vecs.push_back('{0, 1, 32'hA2,        0, 1, 1, 1, 32'hA1, 0, 32'h0,         0, 1}); // push A2 -> full
    vecs.push_back('{0, 1, 32'hA3,        0, 1, 0, 1, 32'hA1, 0, 32'h0,         0, 1}); // lane 0 full
    vecs.push_back('{1, 1, 32'hB1,        0, 1, 1, 1, 32'hA1, 0, 32'h0,         0, 1}); // lane 1 still accepts
    vecs.push_back('{0, 0, 32'h0,         0, 0, 0, 1, 32'hA1, 1, 32'hB1,        0, 1}); // lane 1 stalled
    vecs.push_back('{1, 0, 32'h0,         0, 1, 1, 1, 32'hA1, 1, 32'hB1,        0, 1}); // stable, then pop B1
    vecs.push_back('{0, 1, 32'hA9,        1, 0, 0, 1, 32'hA1, 0, 32'h0,         0, 2}); // pop full lane, no push
    vecs.push_back('{0, 0, 32'h0,         1, 0, 1, 1, 32'hA2, 0, 32'h0,         1, 2}); // ready back, pop A2
    vecs.push_back('{0, 0, 32'h0,         1, 0, 1, 0, 32'h0,  0, 32'h0,         2, 2}); // lane 0 drained
    vecs.push_back('{0, 1, 32'hC1,        1, 0, 1, 0, 32'h0,  0, 32'h0,         2, 2}); // push+pop on empty
    vecs.push_back('{0, 1, 32'hC2,        1, 0, 1, 1, 32'hC1, 0, 32'h0,         2, 2}); // push+pop, occ 1
    vecs.push_back('{0, 0, 32'h0,         0, 0, 1, 1, 32'hC2, 0, 32'h0,         3, 2}); // occupancy still 1
    vecs.push_back('{0, 0, 32'h0,         1, 0, 1, 1, 32'hC2, 0, 32'h0,         3, 2}); // pop C2
    vecs.push_back('{0, 0, 32'h0,         0, 0, 1, 0, 32'h0,  0, 32'h0,         4, 2}); // idle

    // Reset held with a valid beat offered.
    applyStimulus(0, 1, 32'h55, 1, 1);
    step();
    step();
    checkOutput("reset ready", 64'(ready), 64'(0));
    checkOutput("reset valid0", 64'(v0), 64'(0));
    checkOutput("reset valid1", 64'(v1), 64'(0));
    checkOutput("reset cnt0", 64'(c0), 64'(0));
    checkOutput("reset cnt1", 64'(c1), 64'(0));
    applyStimulus(0, 0, 32'h0, 0, 0);
    rst = 1'b0;
    step();
    #1;
    checkOutput("post-reset ready", 64'(ready), 64'(1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].sel, vecs[i].valid, vecs[i].data, vecs[i].rdy0, vecs[i].rdy1);
      #1;
      checkRow($sformatf("vec%0d", i), vecs[i]);
      step();
    end

    // Streaming 0x01..0x10 into lane 0 from a clean state.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 32'(i + 1), 1, 0);
      #1;
      checkOutput($sformatf("stream ready %0d", i), 64'(ready), 64'(1));
      if (i > 0) begin
        checkOutput($sformatf("stream valid0 %0d", i), 64'(v0), 64'(1));
        checkOutput($sformatf("stream data0 %0d", i), 64'(d0), 64'(i));
        checkOutput($sformatf("stream cnt0 %0d", i), 64'(c0), 64'(i - 1));
      end
      step();
    end
    applyStimulus(0, 0, 32'h0, 1, 0);
    #1;
    checkOutput("stream last data0", 64'(d0), 64'h10);
    step();
    checkOutput("stream idle valid0", 64'(v0), 64'(0));
    checkOutput("stream cnt0", 64'(c0), 64'(16));
    checkOutput("stream narrow cnt0", 64'(c0_w), 64'(0));

    // 17 lane-1 deliveries wrap the narrow counter to 1.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 1, 32'(32'h100 + i), 0, 1);
      step();
    end
    applyStimulus(1, 0, 32'h0, 0, 1);
    step();
    checkOutput("wrap cnt1", 64'(c1), 64'(17));
    checkOutput("wrap narrow cnt1", 64'(c1_w), 64'(1));

    // Load both lanes, then reset mid-cycle.
    applyStimulus(0, 1, 32'h77, 0, 0);
    step();
    applyStimulus(1, 1, 32'h88, 0, 0);
    step();
    applyStimulus(0, 1, 32'h99, 0, 0);
    #1;
    checkOutput("preload valid0", 64'(v0), 64'(1));
    checkOutput("preload data1", 64'(d1), 64'h88);
    rst = 1'b1;
    #1;
    checkOutput("midreset ready", 64'(ready), 64'(0));
    checkOutput("midreset lanes", {62'(0), v0, v1}, 64'(0));
    checkOutput("midreset data", {d0, d1}, 64'(0));
    checkOutput("midreset counts", 64'({c0, c1}), 64'(0));
    applyStimulus(0, 0, 32'h0, 0, 0);
    #1;
    rst = 1'b0;
    step();
    checkOutput("after reset ready", 64'(ready), 64'(1));
    checkOutput("after reset lanes", {62'(0), v0, v1}, 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
